unidade_controle_jogadas: RTL and testbench

UNIDADE_CONTROLE_JOGADAS -- requirements
Module: unidade_controle_jogadas

---
 rtl/unidade_controle_jogadas.sv | 121 ++++++++++++
 tb/tb_unidade_controle_jogadas.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogadas.sv
// Play-sequencing control FSM: prepares rounds, waits for plays, compares, ends game.
// In: clock, reset, iniciar, jogada_feita, compare/limit/timeout flags. Out: counter/register strobes, status, db_estado.
module unidade_controle_jogadas (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       chavesIgualMemoria,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL       = 4'h0;
  localparam logic [3:0] PREPARACAO    = 4'h1;
  localparam logic [3:0] INICIO_RODADA = 4'h2;
  localparam logic [3:0] ESPERA        = 4'h3;
  localparam logic [3:0] REGISTRA      = 4'h4;
  localparam logic [3:0] COMPARA       = 4'h5;
  localparam logic [3:0] PROXIMO       = 4'h6;
  localparam logic [3:0] ULTIMA        = 4'h7;
  localparam logic [3:0] PROX_RODADA   = 4'h8;
  localparam logic [3:0] FIM_ACERTO    = 4'hA;
  localparam logic [3:0] FIM_TIMEOUT   = 4'hD;
  localparam logic [3:0] FIM_ERRO      = 4'hE;

  logic [3:0] state_q;
  logic [3:0] state_d;

  always_ff @(posedge clock) begin
    if (reset) state_q <= INICIAL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = INICIAL;
    case (state_q)
      INICIAL:
        state_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:
        state_d = INICIO_RODADA;
      INICIO_RODADA:
        state_d = ESPERA;
      // A play seen together with timeout still wins.
      ESPERA:
        if (jogada_feita) state_d = REGISTRA;
        else if (timeout) state_d = FIM_TIMEOUT;
        else              state_d = ESPERA;
      REGISTRA:
        state_d = COMPARA;
      COMPARA:
        if (!chavesIgualMemoria)      state_d = FIM_ERRO;
        else if (enderecoIgualLimite) state_d = ULTIMA;
        else                          state_d = PROXIMO;
      PROXIMO:
        state_d = ESPERA;
      ULTIMA:
        state_d = fimL ? FIM_ACERTO : PROX_RODADA;
      PROX_RODADA:
        state_d = INICIO_RODADA;
      FIM_ACERTO,
      FIM_TIMEOUT,
      FIM_ERRO:
        state_d = iniciar ? PREPARACAO : state_q;
      default:
        state_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraL      = 1'b0;
    contaL     = 1'b0;
    zeraR      = 1'b0;
    registraR  = 1'b0;
    pronto     = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    db_timeout = 1'b0;
    case (state_q)
      PREPARACAO: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      INICIO_RODADA: zeraE     = 1'b1;
      REGISTRA:      registraR = 1'b1;
      PROXIMO:       contaE    = 1'b1;
      PROX_RODADA:   contaL    = 1'b1;
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto     = 1'b1;
        errou      = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: tb/tb_unidade_controle_jogadas.sv
// Directed bench for unidade_controle_jogadas: vector table plus full-game sequence.
// Outputs packed as {zeraE,contaE,zeraL,contaL,zeraR,registraR,pronto,acertou,errou,db_timeout}.
module tb_unidade_controle_jogadas;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0;
  logic jogada_feita = 1'b0;
  logic chavesIgualMemoria = 1'b0;
  logic enderecoIgualLimite = 1'b0;
  logic fimL = 1'b0;
  logic timeout = 1'b0;
  logic zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic pronto, acertou, errou, db_timeout;
  logic [3:0] db_estado;

  unidade_controle_jogadas dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .jogada_feita(jogada_feita),
    .chavesIgualMemoria(chavesIgualMemoria),
    .enderecoIgualLimite(enderecoIgualLimite),
    .fimL(fimL),
    .timeout(timeout),
    .zeraE(zeraE),
    .contaE(contaE),
    .zeraL(zeraL),
    .contaL(contaL),
    .zeraR(zeraR),
    .registraR(registraR),
    .pronto(pronto),
    .acertou(acertou),
    .errou(errou),
    .db_timeout(db_timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  localparam logic [9:0] O_0 = 10'b0000000000;
  localparam logic [9:0] O_1 = 10'b1010100000;
  localparam logic [9:0] O_2 = 10'b1000000000;
  localparam logic [9:0] O_4 = 10'b0000010000;
  localparam logic [9:0] O_6 = 10'b0100000000;
  localparam logic [9:0] O_8 = 10'b0001000000;
  localparam logic [9:0] O_A = 10'b0000001100;
  localparam logic [9:0] O_E = 10'b0000001010;
  localparam logic [9:0] O_D = 10'b0000001011;

  typedef struct {
    logic       rst;
    logic       ini;
    logic       jf;
    logic       ch;
    logic       eq;
    logic       fl;
    logic       to;
    logic [3:0] st;
    logic [9:0] out;
  } vec_t;

  vec_t vecs[$];
  int nvec = 0;
  int nerr = 0;
  int ncl  = 0;
  int nce  = 0;

  function automatic logic [9:0] outs();
    return {zeraE, contaE, zeraL, contaL, zeraR,
            registraR, pronto, acertou, errou, db_timeout};
  endfunction

  task automatic add(input logic rst, ini, jf, ch, eq, fl, to,
                     input logic [3:0] st, input logic [9:0] out);
    vec_t v;
    v.rst = rst; v.ini = ini; v.jf = jf; v.ch = ch;
    v.eq = eq; v.fl = fl; v.to = to; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  task automatic cyc(input logic rst, ini, jf, ch, eq, fl, to);
    reset = rst; iniciar = ini; jogada_feita = jf;
    chavesIgualMemoria = ch; enderecoIgualLimite = eq;
    fimL = fl; timeout = to;
    @(posedge clock);
    #1;
    if (contaL) ncl++;
    if (contaE) nce++;
  endtask

  task automatic chk(input string nm, input logic [3:0] st,
                     input logic [9:0] out);
    nvec++;
    if (db_estado !== st || outs() !== out) begin
      nerr++;
      $display("FAIL %s: got st=%h out=%b, want st=%h out=%b",
               nm, db_estado, outs(), st, out);
    end
  endtask

  initial begin
    //  rst ini jf ch eq fl to  st    out
    add(1, 0, 0, 0, 0, 0, 0, 4'h0, O_0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, O_0);
    add(0, 1, 0, 0, 0, 0, 0, 4'h1, O_1);
    add(0, 0, 0, 0, 0, 0, 0, 4'h2, O_2);
    add(0, 0, 0, 0, 0, 0, 0, 4'h3, O_0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h3, O_0);
    add(0, 0, 1, 1, 1, 0, 0, 4'h4, O_4);
    add(0, 0, 0, 1, 1, 0, 0, 4'h5, O_0);
    add(0, 0, 0, 1, 1, 0, 0, 4'h7, O_0);
    add(0, 0, 0, 1, 1, 0, 0, 4'h8, O_8);
    add(0, 0, 0, 1, 1, 0, 0, 4'h2, O_2);
    add(0, 0, 0, 1, 1, 0, 0, 4'h3, O_0);
    add(0, 0, 1, 1, 0, 0, 0, 4'h4, O_4);
    add(0, 0, 0, 1, 0, 0, 0, 4'h5, O_0);
    add(0, 0, 0, 1, 0, 0, 0, 4'h6, O_6);
    add(0, 0, 0, 1, 0, 0, 0, 4'h3, O_0);
    add(0, 1, 0, 1, 0, 0, 0, 4'h3, O_0);
    add(0, 0, 1, 1, 0, 0, 0, 4'h4, O_4);
    add(0, 0, 0, 1, 0, 0, 0, 4'h5, O_0);
    add(0, 0, 0, 0, 0, 0, 0, 4'hE, O_E);
    add(0, 0, 0, 0, 0, 0, 0, 4'hE, O_E);
    add(0, 1, 0, 0, 0, 0, 0, 4'h1, O_1);
    add(0, 0, 0, 0, 0, 0, 0, 4'h2, O_2);
    add(0, 0, 0, 0, 0, 0, 0, 4'h3, O_0);
    add(0, 0, 0, 0, 0, 0, 1, 4'hD, O_D);
    add(0, 0, 0, 0, 0, 0, 1, 4'hD, O_D);
    add(0, 1, 0, 0, 0, 0, 0, 4'h1, O_1);
    add(0, 1, 0, 0, 0, 0, 0, 4'h2, O_2);
    add(0, 0, 0, 0, 0, 0, 0, 4'h3, O_0);
    add(0, 0, 1, 0, 0, 0, 1, 4'h4, O_4);
    add(0, 0, 0, 0, 0, 0, 0, 4'h5, O_0);
    add(0, 0, 0, 0, 0, 0, 0, 4'hE, O_E);
    add(1, 1, 0, 0, 0, 0, 0, 4'h0, O_0);
    add(0, 0, 0, 0, 0, 0, 0, 4'h0, O_0);
    add(0, 1, 0, 0, 0, 0, 0, 4'h1, O_1);
    add(0, 0, 0, 0, 0, 0, 0, 4'h2, O_2);
    add(0, 0, 1, 1, 1, 1, 1, 4'h3, O_0);
    add(1, 0, 1, 1, 1, 1, 1, 4'h0, O_0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].ini, vecs[i].jf, vecs[i].ch,
          vecs[i].eq, vecs[i].fl, vecs[i].to);
      chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].out);
    end

    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("game_prep", 4'h1, O_1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("game_wait", 4'h3, O_0);
    ncl = 0;
    nce = 0;
    for (int r = 0; r < 16; r++) begin
      for (int a = 0; a <= r; a++) begin
        logic e, f;
        e = (a == r);
        f = (r == 15);
        cyc(0, 0, 1, 1, e, f, 0);
        chk("game_reg", 4'h4, O_4);
        cyc(0, 0, 0, 1, e, f, 0);
        chk("game_cmp", 4'h5, O_0);
        cyc(0, 0, 0, 1, e, f, 0);
        if (!e) begin
          chk("game_next", 4'h6, O_6);
          cyc(0, 0, 0, 1, e, f, 0);
          chk("game_back", 4'h3, O_0);
        end else begin
          chk("game_last", 4'h7, O_0);
          cyc(0, 0, 0, 1, e, f, 0);
          if (f) begin
            chk("game_win", 4'hA, O_A);
          end else begin
            chk("game_round", 4'h8, O_8);
            cyc(0, 0, 0, 1, e, f, 0);
            chk("game_ini", 4'h2, O_2);
            cyc(0, 0, 0, 1, e, f, 0);
            chk("game_wait2", 4'h3, O_0);
          end
        end
      end
    end
    nvec++;
    if (ncl != 15) begin
      nerr++;
      $display("FAIL contaL_count: got %0d, want 15", ncl);
    end
    nvec++;
    if (nce != 120) begin
      nerr++;
      $display("FAIL contaE_count: got %0d, want 120", nce);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("win_hold", 4'hA, O_A);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("win_restart", 4'h1, O_1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("restart_ini", 4'h2, O_2);
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 1);
    chk("to_again", 4'hD, O_D);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rst_fim", 4'h0, O_0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
